// File: rtl/hilo_muldiv_unit.sv
// rtl/hilo_muldiv_unit.sv - HI/LO multiply/divide unit with fixed-latency busy window
// Operands are latched at accept; the result is computed from them and committed on the last busy edge.
module hilo_muldiv_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             we,
  input  logic             sel_hi,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [2:0]         op_q, op_d;
  logic               div_zero_q, div_zero_d;

  logic [2*WIDTH-1:0] ext_a, ext_b, prod, acc;
  logic [WIDTH-1:0]   a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;
  logic               a_neg, b_neg, is_div_q;

  // op[0] selects signed interpretation for every op class
  always_comb begin
    ext_a  = op_q[0] ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    ext_b  = op_q[0] ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    prod   = ext_a * ext_b;
    acc    = {hi_q, lo_q};
    a_neg  = op_q[0] & a_q[WIDTH-1];
    b_neg  = op_q[0] & b_q[WIDTH-1];
    a_mag  = a_neg ? -a_q : a_q;
    b_mag  = b_neg ? -b_q : b_q;
    b_safe = (b_mag == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    // MIN / -1 wraps naturally: the magnitude quotient negates back to MIN, remainder 0
    quot   = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem    = a_neg ? -r_mag : r_mag;
    is_div_q = (op_q[2:1] == 2'b01);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = div_zero_q;
    case (state_q)
      IDLE: begin
        if (we) begin
          if (sel_hi) hi_d = a;
          else        lo_d = a;
        end
        if (start) begin
          state_d    = BUSY;
          a_d        = a;
          b_d        = b;
          op_d       = op;
          cnt_d      = (op[2:1] == 2'b01) ? CW'(DIV_LAT - 1) : CW'(MUL_LAT - 1);
          div_zero_d = (op[2:1] == 2'b01) && (b == '0);
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          if (is_div_q) begin
            if (b_q != '0) begin
              hi_d = rem;
              lo_d = quot;
            end
          end else if (!op_q[2]) begin
            {hi_d, lo_d} = prod;
          end else if (!op_q[1]) begin
            {hi_d, lo_d} = acc + prod;
          end else begin
            {hi_d, lo_d} = acc - prod;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy     = (state_q == BUSY);
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb/tb_hilo_muldiv_unit.sv - scoreboard bench for hilo_muldiv_unit
// Expected HI/LO/div_zero/latency are pushed at launch and popped when busy falls.
module tb_hilo_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset, start, we, sel_hi;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, div_zero;
  logic [31:0] hi, lo;

  hilo_muldiv_unit #(.WIDTH(32), .MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .we(we), .sel_hi(sel_hi), .busy(busy), .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_hi, m_lo;
  logic        m_dz;
  int          n_cmp = 0;
  int          n_err = 0;

  function automatic exp_t model_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    logic [63:0] p;
    if (o[0]) p = {{32{x[31]}}, x} * {{32{y[31]}}, y};
    else      p = {32'b0, x} * {32'b0, y};
    if (o[2:1] == 2'b01) begin
      e.lat = 10;
      m_dz  = (y == 0);
      if (y != 0) begin
        if (!o[0]) begin
          m_lo = x / y;
          m_hi = x % y;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          m_lo = 32'h8000_0000;
          m_hi = 32'h0;
        end else begin
          m_lo = $signed(x) / $signed(y);
          m_hi = $signed(x) % $signed(y);
        end
      end
    end else begin
      e.lat = 5;
      m_dz  = 1'b0;
      if (!o[2])      {m_hi, m_lo} = p;
      else if (!o[1]) {m_hi, m_lo} = {m_hi, m_lo} + p;
      else            {m_hi, m_lo} = {m_hi, m_lo} - p;
    end
    e.hi = m_hi;
    e.lo = m_lo;
    e.dz = m_dz;
    return e;
  endfunction

  // All tasks start and end at a falling edge.
  task automatic launch(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    sb.push_back(model_op(o, x, y));
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom);
  endtask

  task automatic write_reg(input logic h, input logic [31:0] v);
    if (h) m_hi = v; else m_lo = v;
    we = 1'b1; sel_hi = h; a = v;
    @(negedge clk);
    we = 1'b0;
  endtask

  // Counts busy cycles; optionally pokes start/we mid-flight, which must be ignored.
  task automatic wait_idle(output int n, input bit poke);
    n = 0;
    while (busy && n < 50) begin
      n++;
      if (poke && n == 2) begin
        start = 1'b1; op = 3'b100; a = 32'h1234; b = 32'h5678; we = 1'b1; sel_hi = 1'b1;
      end
      @(negedge clk);
      start = 1'b0; we = 1'b0;
    end
  endtask

  task automatic run_and_check(input string name, input logic [2:0] o, input logic [31:0] x,
                               input logic [31:0] y, input bit poke);
    int   n;
    exp_t e;
    launch(o, x, y);
    wait_idle(n, poke);
    e = sb.pop_front();
    n_cmp++;
    if ({8'(n), hi, lo, div_zero} !== {8'(e.lat), e.hi, e.lo, e.dz}) begin
      n_err++;
      $display("FAIL %s: got lat=%0d hi=%h lo=%h dz=%b, want lat=%0d hi=%h lo=%h dz=%b",
               name, n, hi, lo, div_zero, e.lat, e.hi, e.lo, e.dz);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_hi = 0; m_lo = 0; m_dz = 0;
    n_cmp++; if (busy !== 1'b0)     begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (hi !== 32'h0)      begin n_err++; $display("FAIL reset_hi: got %h want 0", hi); end
    n_cmp++; if (lo !== 32'h0)      begin n_err++; $display("FAIL reset_lo: got %h want 0", lo); end
    n_cmp++; if (div_zero !== 1'b0) begin n_err++; $display("FAIL reset_dz: got %b want 0", div_zero); end
  endtask

  task automatic test_mul_div;
    run_and_check("multu_poke", 3'b000, 32'hFFFF_FFFF, 32'h2, 1'b1);
    n_cmp++;
    if ({hi, lo} !== 64'h1_FFFF_FFFE) begin
      n_err++; $display("FAIL multu_const: got %h%h want 00000001fffffffe", hi, lo);
    end
    run_and_check("mult", 3'b001, -32'sd3, 32'd7, 1'b0);
    run_and_check("div", 3'b011, -32'sd7, 32'd2, 1'b0);
    n_cmp++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      n_err++; $display("FAIL div_const: got %h%h want fffffffffffffffd", hi, lo);
    end
    run_and_check("divu", 3'b010, 32'd1000, 32'd7, 1'b0);
  endtask

  task automatic test_accumulate;
    write_reg(1'b1, 32'h0);
    write_reg(1'b0, 32'd10);
    n_cmp++;
    if ({hi, lo} !== {32'h0, 32'd10}) begin
      n_err++; $display("FAIL direct_write: got %h/%h want 0/10", hi, lo);
    end
    run_and_check("maddu", 3'b100, 32'd3, 32'd4, 1'b0);
    run_and_check("msub", 3'b111, 32'd1, 32'hFFFF_FFFF, 1'b0);
    n_cmp++;
    if ({hi, lo} !== {32'h0, 32'd23}) begin
      n_err++; $display("FAIL msub_const: got %h/%h want 0/23", hi, lo);
    end
    run_and_check("madd_neg", 3'b101, -32'sd5, 32'd9, 1'b0);
    run_and_check("msubu_wrap", 3'b110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
  endtask

  task automatic test_div_zero;
    write_reg(1'b1, 32'd5);
    write_reg(1'b0, 32'd6);
    run_and_check("divu_zero_poke", 3'b010, 32'd77, 32'd0, 1'b1);
    n_cmp++;
    if ({hi, lo, div_zero} !== {32'd5, 32'd6, 1'b1}) begin
      n_err++; $display("FAIL div_zero_hold: got %h/%h dz=%b want 5/6 dz=1", hi, lo, div_zero);
    end
    run_and_check("multu_clear_dz", 3'b000, 32'd6, 32'd7, 1'b0);
    run_and_check("div_min_neg1", 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
  endtask

  task automatic test_write_with_start;
    int   n;
    exp_t e;
    m_lo = 32'd100;
    sb.push_back(model_op(3'b100, 32'd100, 32'd3));
    we = 1'b1; sel_hi = 1'b0; start = 1'b1; op = 3'b100; a = 32'd100; b = 32'd3;
    @(negedge clk);
    we = 1'b0; start = 1'b0; a = $urandom; b = $urandom;
    wait_idle(n, 1'b0);
    e = sb.pop_front();
    n_cmp++;
    if ({8'(n), hi, lo} !== {8'(e.lat), e.hi, e.lo}) begin
      n_err++; $display("FAIL write_start: got lat=%0d hi=%h lo=%h want lat=%0d hi=%h lo=%h",
                        n, hi, lo, e.lat, e.hi, e.lo);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 12; i++) begin
      logic [2:0]  o;
      logic [31:0] y;
      o = 3'($urandom);
      y = (i == 3) ? 32'h0 : $urandom;
      run_and_check($sformatf("b2b_%0d", i), o, $urandom, y, i[0]);
    end
  endtask

  task automatic test_reset_abort;
    write_reg(1'b1, 32'd9);
    launch(3'b011, 32'd100, 32'd7);
    void'(sb.pop_front());
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi = 0; m_lo = 0; m_dz = 0;
    n_cmp++;
    if ({busy, hi, lo, div_zero} !== 66'h0) begin
      n_err++; $display("FAIL abort_now: got busy=%b hi=%h lo=%h dz=%b want all 0", busy, hi, lo, div_zero);
    end
    repeat (15) @(negedge clk);
    n_cmp++;
    if ({busy, hi, lo} !== 65'h0) begin
      n_err++; $display("FAIL abort_later: got busy=%b hi=%h lo=%h want all 0", busy, hi, lo);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; we = 1'b0; sel_hi = 1'b0; op = 3'b0; a = 0; b = 0;
    @(negedge clk);
    test_reset();
    test_mul_div();
    test_accumulate();
    test_div_zero();
    test_write_with_start();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
